// File: rtl/cic_sched_pkg.sv
// Shared state/source types and framing constants for the CIC readout scheduler.
package cic_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } sched_state_e;

  typedef enum logic {
    SRC_S0 = 1'b0,
    SRC_S1 = 1'b1
  } src_id_e;

  localparam logic HDR_SYNC = 1'b1;
  localparam int   S0_BYTES = 2;
  localparam int   S1_BYTES = 3;
  localparam int   SHIFT_W  = 8 * S1_BYTES;

  function automatic logic [7:0] hdr_byte(input src_id_e src, input logic pend);
    return {HDR_SYNC, src, pend, 5'b0};
  endfunction

endpackage

// File: rtl/cic_sample_holder.sv
// One-entry sample holder: loads on strobe when empty or being freed, flags overrun when a strobe finds it full.
module cic_sample_holder
  import cic_sched_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             free_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overrun_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  // A holder being drained this cycle can take the new sample without loss.
  assign accept    = load_i && (!full_q || free_i);
  assign overrun_o = load_i && full_q && !free_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (free_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/cic_readout_scheduler.sv
// Round-robin framer of two CIC sample streams into header+data bytes over valid/ready; header one cycle after capture.
// Optional CIC_SCHED_OVR_COUNT_EN adds a saturating 8-bit dropped-sample counter on ovr_cnt_o.
module cic_readout_scheduler
  import cic_sched_pkg::*;
#(
  parameter int W0 = 10,
  parameter int W1 = 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s0_valid_i,
  input  logic [W0-1:0] s0_data_i,
  input  logic          s1_valid_i,
  input  logic [W1-1:0] s1_data_i,
  input  logic [1:0]    src_en_i,
  output logic [7:0]    byte_o,
  output logic          byte_valid_o,
  input  logic          byte_ready_i,
  output logic          frame_last_o,
  output logic          busy_o,
  output logic [1:0]    ovr_o,
  input  logic          ovr_clr_i
`ifdef CIC_SCHED_OVR_COUNT_EN
  ,
  output logic [7:0]    ovr_cnt_o
`endif
);

  sched_state_e         state_q, state_d;
  src_id_e              rr_q, rr_d, gsrc;
  logic [1:0]           pend_q, pend_d, ovr_q, ovr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 vld_q, vld_d, last_q, last_d;
  logic [SHIFT_W-1:0]   sh_q, sh_d;
  logic [1:0]           rem_q, rem_d;
  logic [1:0]           full, overrun, free;
  logic [W0-1:0]        h0_data;
  logic [W1-1:0]        h1_data;
  logic                 xfer, frame_done, grant;

  cic_sample_holder #(.WIDTH(W0)) u_hold0 (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(s0_valid_i && src_en_i[0]), .data_i(s0_data_i),
    .free_i(free[0]), .full_o(full[0]), .data_o(h0_data), .overrun_o(overrun[0])
  );

  cic_sample_holder #(.WIDTH(W1)) u_hold1 (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(s1_valid_i && src_en_i[1]), .data_i(s1_data_i),
    .free_i(free[1]), .full_o(full[1]), .data_o(h1_data), .overrun_o(overrun[1])
  );

  assign xfer       = vld_q && byte_ready_i;
  assign frame_done = (state_q == ST_DATA) && xfer && last_q;
  // Granting straight out of the final data byte is what keeps back-to-back frames bubble-free.
  assign grant      = (|full) && ((state_q == ST_IDLE) || frame_done);
  assign gsrc       = (&full) ? rr_q : (full[1] ? SRC_S1 : SRC_S0);
  assign free       = grant ? ((gsrc == SRC_S1) ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= SRC_S0;
      pend_q  <= 2'b00;
      ovr_q   <= 2'b00;
      byte_q  <= 8'h00;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      sh_q    <= '0;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|full) state_d = ST_HDR;
      ST_HDR:  if (xfer) state_d = ST_DATA;
      ST_DATA: if (frame_done) state_d = (|full) ? ST_HDR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_d = byte_q;
    vld_d  = vld_q;
    last_d = last_q;
    sh_d   = sh_q;
    rem_d  = rem_q;
    rr_d   = rr_q;
    pend_d = (pend_q & ~free) | overrun;
    ovr_d  = ovr_clr_i ? 2'b00 : (ovr_q | overrun);
    if (grant) begin
      byte_d = hdr_byte(gsrc, pend_q[gsrc]);
      vld_d  = 1'b1;
      last_d = 1'b0;
      rr_d   = (gsrc == SRC_S0) ? SRC_S1 : SRC_S0;
      // Data is left-aligned so every source drains from the top byte.
      if (gsrc == SRC_S1) begin
        sh_d  = SHIFT_W'(h1_data);
        rem_d = 2'(S1_BYTES);
      end else begin
        sh_d  = SHIFT_W'(h0_data) << (8 * (S1_BYTES - S0_BYTES));
        rem_d = 2'(S0_BYTES);
      end
    end else if (xfer && !last_q) begin
      byte_d = sh_q[SHIFT_W-1 -: 8];
      sh_d   = sh_q << 8;
      rem_d  = rem_q - 2'd1;
      last_d = (rem_q == 2'd1);
    end else if (xfer) begin
      byte_d = 8'h00;
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

`ifdef CIC_SCHED_OVR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 9'(overrun[0]) + 9'(overrun[1]);
    cnt_d   = ovr_clr_i ? 8'd0 : ((cnt_sum > 9'd255) ? 8'hFF : cnt_sum[7:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign ovr_cnt_o = cnt_q;
`endif

  assign byte_o       = byte_q;
  assign byte_valid_o = vld_q;
  assign frame_last_o = last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign ovr_o        = ovr_q;

endmodule

// File: tb/tb_cic_readout_scheduler.sv
// Bench for cic_readout_scheduler: queue-based frame model checked every cycle, plus literal frame expectations.
module tb_cic_readout_scheduler;

  localparam int W0 = 10;
  localparam int W1 = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_v = 1'b0, s1_v = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [W0-1:0] s0_d = '0;
  logic [W1-1:0] s1_d = '0;
  logic [1:0]    en = 2'b11;
  logic [7:0]    byte_o;
  logic          byte_valid, frame_last, busy;
  logic [1:0]    ovr;
`ifdef CIC_SCHED_OVR_COUNT_EN
  logic [7:0]    ovr_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: bytes still to be presented for the current frame ({last, byte}), front is on the bus.
  logic [8:0]  mq[$];
  bit          m_full[2] = '{0, 0};
  logic [23:0] m_data[2];
  bit          m_pend[2] = '{0, 0};
  bit          m_rr = 1'b0;
  logic [1:0]  m_ovr = 2'b00;
  int          m_cnt = 0;

  logic [8:0]  log_q[$];
  int          log_cyc[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  eb;
  logic        ev, el;

  always #5 clk = ~clk;

  cic_readout_scheduler #(.W0(W0), .W1(W1)) dut (
    .clk_i(clk), .rst_i(rst),
    .s0_valid_i(s0_v), .s0_data_i(s0_d),
    .s1_valid_i(s1_v), .s1_data_i(s1_d),
    .src_en_i(en),
    .byte_o(byte_o), .byte_valid_o(byte_valid), .byte_ready_i(ready),
    .frame_last_o(frame_last), .busy_o(busy),
    .ovr_o(ovr), .ovr_clr_i(clr)
`ifdef CIC_SCHED_OVR_COUNT_EN
    , .ovr_cnt_o(ovr_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ovf[2];
    int src, n;
    logic [23:0] v;
    ovf = '{0, 0};
    if (rst) begin
      mq.delete();
      m_full = '{0, 0};
      m_pend = '{0, 0};
      m_rr = 1'b0;
      m_ovr = 2'b00;
      m_cnt = 0;
      return;
    end
    if (mq.size() > 0 && ready) void'(mq.pop_front());
    if (mq.size() == 0 && (m_full[0] || m_full[1])) begin
      src = (m_full[0] && m_full[1]) ? int'(m_rr) : (m_full[1] ? 1 : 0);
      mq.push_back({1'b0, 1'b1, src[0], m_pend[src], 5'b0});
      n = (src == 1) ? 3 : 2;
      v = m_data[src];
      for (int b = n - 1; b >= 0; b--) mq.push_back({b == 0, v[8*b +: 8]});
      m_full[src] = 1'b0;
      m_pend[src] = 1'b0;
      m_rr = (src == 0);
    end
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 ? s0_v : s1_v) && en[i]) begin
        if (m_full[i]) ovf[i] = 1'b1;
        else begin
          m_full[i] = 1'b1;
          m_data[i] = (i == 0) ? 24'(s0_d) : 24'(s1_d);
        end
      end
    end
    for (int i = 0; i < 2; i++) if (ovf[i]) m_pend[i] = 1'b1;
    if (clr) begin
      m_ovr = 2'b00;
      m_cnt = 0;
    end else begin
      m_ovr = m_ovr | {ovf[1], ovf[0]};
      m_cnt = m_cnt + int'(ovf[0]) + int'(ovf[1]);
      if (m_cnt > 255) m_cnt = 255;
    end
  endtask

  // Compare, log the transfer that the coming edge will perform, then advance the model past that edge.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      ev = (mq.size() > 0);
      eb = ev ? mq[0][7:0] : 8'h00;
      el = ev ? mq[0][8] : 1'b0;
      check("cycle_outputs{byte,vld,last,busy,ovr}",
            32'({byte_o, byte_valid, frame_last, busy, ovr}),
            32'({eb, ev, el, ev, m_ovr}));
`ifdef CIC_SCHED_OVR_COUNT_EN
      check("cycle_ovr_cnt", 32'(ovr_cnt), 32'(m_cnt));
`endif
    end
    if (byte_valid === 1'b1 && ready && !rst) begin
      log_q.push_back({frame_last, byte_o});
      log_cyc.push_back(cyc);
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    s0_v = 1'b0;
    s1_v = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    tests++;
    if (log_q.size() < n) begin
      fails++;
      $display("FAIL %s: saw %0d bytes within %0d cycles, expected %0d", name, log_q.size(), budget, n);
    end
  endtask

  task automatic check_bytes(input string name);
    for (int i = 0; i < exp_q.size(); i++)
      check(name, 32'((i < log_q.size()) ? log_q[i] : 9'h1FF), 32'(exp_q[i]));
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_byte", 32'(byte_o), 0);
    check("rst_valid", 32'(byte_valid), 0);
    check("rst_last", 32'(frame_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(ovr), 0);

    // Simultaneous strobes right after reset: s0 first, s1 follows with no gap.
    clear_log();
    ready = 1'b1;
    s0_d = 10'h001; s0_v = 1'b1;
    s1_d = 20'hABCDE; s1_v = 1'b1;
    tick();
    wait_log("both_frames", 7, 30);
    exp_q = {9'h080, 9'h000, 9'h101, 9'h0C0, 9'h00A, 9'h0BC, 9'h1DE};
    check_bytes("both_frames");
    if (log_cyc.size() >= 4) check("both_no_gap", 32'(log_cyc[3] - log_cyc[2]), 1);
    repeat (3) tick();

    // Single s0 sample and capture-to-header latency.
    clear_log();
    s0_d = 10'h2A5; s0_v = 1'b1;
    tick();
    check("lat_edge_k_valid", 32'(byte_valid), 0);
    tick();
    check("lat_edge_k1_valid", 32'(byte_valid), 1);
    check("lat_edge_k1_byte", 32'(byte_o), 32'h80);
    wait_log("s0_frame", 3, 20);
    exp_q = {9'h080, 9'h002, 9'h1A5};
    check_bytes("s0_frame");
    repeat (3) tick();

    // Backpressure on the header.
    clear_log();
    ready = 1'b0;
    s0_d = 10'h3C3; s0_v = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_byte", 32'(byte_o), 32'h80);
      check("bp_hold_valid", 32'(byte_valid), 1);
      tick();
    end
    ready = 1'b1;
    wait_log("bp_frame", 3, 20);
    exp_q = {9'h080, 9'h003, 9'h1C3};
    check_bytes("bp_frame");
    repeat (3) tick();

    // Overrun on s1 while an s0 frame is stalled.
    clear_log();
    ready = 1'b0;
    s0_d = 10'h155; s0_v = 1'b1;
    tick();
    s1_d = 20'h12345; s1_v = 1'b1;
    tick();
    s1_d = 20'h6789A; s1_v = 1'b1;
    tick();
    check("ovr_set", 32'(ovr), 32'h2);
`ifdef CIC_SCHED_OVR_COUNT_EN
    check("ovr_cnt_one", 32'(ovr_cnt), 1);
`endif
    ready = 1'b1;
    wait_log("ovr_frames", 7, 30);
    exp_q = {9'h080, 9'h001, 9'h155, 9'h0E0, 9'h001, 9'h023, 9'h145};
    check_bytes("ovr_frames");
    check("ovr_sticky", 32'(ovr), 32'h2);
    clr = 1'b1;
    tick();
    check("ovr_cleared", 32'(ovr), 0);
`ifdef CIC_SCHED_OVR_COUNT_EN
    check("ovr_cnt_cleared", 32'(ovr_cnt), 0);
`endif
    repeat (3) tick();

    // Reset in the middle of an s1 frame.
    clear_log();
    s1_d = 20'hFEDCB; s1_v = 1'b1;
    tick();
    wait_log("rst_mid_hdr", 1, 10);
    check("rst_mid_hdr_byte", 32'(log_q[0]), 32'h0C0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outputs", 32'({byte_o, byte_valid, frame_last, busy, ovr}), 0);
    clear_log();
    repeat (10) tick();
    check("rst_mid_quiet", 32'(log_q.size()), 0);

    // Disabled source ignores its strobe.
    en = 2'b01;
    clear_log();
    s1_d = 20'h55555; s1_v = 1'b1;
    tick();
    repeat (8) tick();
    check("dis_no_frame", 32'(log_q.size()), 0);
    check("dis_busy", 32'(busy), 0);
    check("dis_ovr", 32'(ovr), 0);
    en = 2'b11;

    // Randomized traffic, checked each cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      s0_v  = ($urandom_range(0, 99) < 30);
      s0_d  = 10'($urandom);
      s1_v  = ($urandom_range(0, 99) < 30);
      s1_d  = 20'($urandom);
      ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) en = 2'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0;
    en = 2'b11;
    ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
